// File: rtl/cdb_arbiter_if.sv
// Common Data Bus arbiter port bundle: FU result handshake in, registered CDB broadcast out.
// master = FU/producer side, slave = arbiter.
interface cdb_arbiter_if #(
    parameter int N_REQ = 8,
    parameter int DW    = 32,
    parameter int TAGW  = 5
);
    logic [N_REQ-1:0]           req_valid;
    logic [N_REQ*TAGW-1:0]      req_tag;
    logic [N_REQ*DW-1:0]        req_data;
    logic [N_REQ-1:0]           req_ready;
    logic [N_REQ-1:0]           flush_mask;
    logic [N_REQ:0]             CDB_result;
    logic                       cdb_valid;
    logic [TAGW-1:0]            cdb_tag;
    logic [DW-1:0]              cdb_data;
    logic                       reg_we;
    logic [$clog2(N_REQ+1)-1:0] slots_busy;

    modport master (
        output req_valid, req_tag, req_data, flush_mask,
        input  req_ready, CDB_result, cdb_valid, cdb_tag, cdb_data, reg_we, slots_busy
    );
    modport slave (
        input  req_valid, req_tag, req_data, flush_mask,
        output req_ready, CDB_result, cdb_valid, cdb_tag, cdb_data, reg_we, slots_busy
    );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one 1-entry slot per FU, one registered broadcast per cycle.
// Define CDB_RR_EN for round-robin arbitration; default is fixed priority (lowest index wins).
module cdb_slot #(
    parameter int DW   = 32,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            grant,
    input  logic            flush,
    input  logic [TAGW-1:0] tag_in,
    input  logic [DW-1:0]   data_in,
    output logic            v,
    output logic            v_nxt,
    output logic [TAGW-1:0] tag,
    output logic [DW-1:0]   data
);
    // flush beats a same-cycle load; load beats drain so load+drain keeps the slot full
    always_comb begin
        v_nxt = v;
        if (flush)      v_nxt = 1'b0;
        else if (load)  v_nxt = 1'b1;
        else if (grant) v_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v    <= 1'b0;
            tag  <= '0;
            data <= '0;
        end else begin
            v <= v_nxt;
            if (load && !flush) begin
                tag  <= tag_in;
                data <= data_in;
            end
        end
    end
endmodule

module cdb_arbiter #(
    parameter int N_REQ = 8,
    parameter int DW    = 32,
    parameter int TAGW  = 5
) (
    input  logic         clk,
    input  logic         rst,
    cdb_arbiter_if.slave bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(N_REQ + 1);

    logic [N_REQ-1:0]            slot_v, slot_v_nxt, elig, grant, load;
    logic [N_REQ-1:0][TAGW-1:0]  slot_tag;
    logic [N_REQ-1:0][DW-1:0]    slot_data;
    logic                        gnt_any;
    logic [IW-1:0]               gnt_idx;
    logic [CW-1:0]               busy_nxt, busy_r;
    logic                        out_v, kill;
    logic [N_REQ:0]              out_oh;
    logic [TAGW-1:0]             tag_r;
    logic [DW-1:0]               data_r;

    assign elig          = slot_v & ~bus.flush_mask;
    assign grant         = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;
    assign bus.req_ready = ~slot_v | grant;
    assign load          = bus.req_valid & bus.req_ready;

    for (genvar i = 0; i < N_REQ; i++) begin : g_slot
        cdb_slot #(.DW(DW), .TAGW(TAGW)) u_slot (
            .clk     (clk),
            .rst     (rst),
            .load    (load[i]),
            .grant   (grant[i]),
            .flush   (bus.flush_mask[i]),
            .tag_in  (bus.req_tag[i*TAGW +: TAGW]),
            .data_in (bus.req_data[i*DW +: DW]),
            .v       (slot_v[i]),
            .v_nxt   (slot_v_nxt[i]),
            .tag     (slot_tag[i]),
            .data    (slot_data[i])
        );
    end

`ifdef CDB_RR_EN
    logic [IW-1:0] rr_ptr, idx;

    // Walk downward so the candidate closest to rr_ptr is the last (winning) assignment
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(rr_ptr) + k) % N_REQ);
            if (elig[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         rr_ptr <= '0;
        else if (gnt_any) rr_ptr <= IW'((int'(gnt_idx) + 1) % N_REQ);
    end
`else
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (elig[k]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(k);
            end
        end
    end
`endif

    always_comb begin
        busy_nxt = '0;
        for (int k = 0; k < N_REQ; k++) busy_nxt = busy_nxt + CW'(slot_v_nxt[k]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_v  <= 1'b0;
            out_oh <= (N_REQ+1)'(1);
            tag_r  <= '0;
            data_r <= '0;
            busy_r <= '0;
        end else begin
            out_v  <= gnt_any;
            out_oh <= gnt_any ? {grant, 1'b0} : (N_REQ+1)'(1);
            busy_r <= busy_nxt;
            if (gnt_any) begin
                tag_r  <= slot_tag[gnt_idx];
                data_r <= slot_data[gnt_idx];
            end
        end
    end

    // A late flush of the source currently on the bus cancels the broadcast in place
    assign kill           = |(out_oh[N_REQ:1] & bus.flush_mask);
    assign bus.cdb_valid  = out_v & ~kill;
    assign bus.CDB_result = kill ? (N_REQ+1)'(1) : out_oh;
    assign bus.cdb_tag    = tag_r;
    assign bus.cdb_data   = data_r;
    assign bus.reg_we     = bus.cdb_valid & (tag_r != '0);
    assign bus.slots_busy = busy_r;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed vectors push expected broadcasts, a negedge
// monitor pops and compares every cdb_valid cycle.
module tb_cdb_arbiter;
    localparam int N  = 8;
    localparam int DW = 32;
    localparam int TW = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.N_REQ(N), .DW(DW), .TAGW(TW)) bus ();
    cdb_arbiter #(.N_REQ(N), .DW(DW), .TAGW(TW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int            src;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
        bus.req_valid[i]          = 1'b1;
        bus.req_tag[i*TW +: TW]   = t;
        bus.req_data[i*DW +: DW]  = d;
    endtask

    task automatic expect_bc(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
        exp_t e;
        e.src  = i;
        e.tag  = t;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic settle(input string name);
        repeat (4) tick();
        check(name, 64'(sb.size()), 64'(0));
    endtask

    // Monitor: every broadcast must match the next expected entry
    always @(negedge clk) begin
        if (rst && bus.cdb_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL cdb_unexpected: got src %0h expected no broadcast @%0t",
                         bus.CDB_result, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("mon_cdb_result", 64'(bus.CDB_result), 64'(1) << (e.src + 1));
                check("mon_cdb_tag",    64'(bus.cdb_tag),    64'(e.tag));
                check("mon_cdb_data",   64'(bus.cdb_data),   64'(e.data));
                check("mon_reg_we",     64'(bus.reg_we),     64'(e.tag != '0));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        bus.req_valid  = '0;
        bus.req_tag    = '0;
        bus.req_data   = '0;
        bus.flush_mask = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cdb_valid",  64'(bus.cdb_valid),  64'(0));
        check("rst_cdb_result", 64'(bus.CDB_result), 64'(1));
        check("rst_cdb_tag",    64'(bus.cdb_tag),    64'(0));
        check("rst_cdb_data",   64'(bus.cdb_data),   64'(0));
        check("rst_reg_we",     64'(bus.reg_we),     64'(0));
        check("rst_slots_busy", 64'(bus.slots_busy), 64'(0));
        check("rst_req_ready",  64'(bus.req_ready),  64'(8'hFF));
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Single request, two-edge latency, one-cycle broadcast
        drive(2, 5'd5, 32'hDEADBEEF);
        expect_bc(2, 5'd5, 32'hDEADBEEF);
        @(negedge clk);
        check("t1_lat0_valid", 64'(bus.cdb_valid), 64'(0));
        tick();
        bus.req_valid = '0;
        check("t1_busy", 64'(bus.slots_busy), 64'(1));
        @(negedge clk);
        check("t1_lat1_valid", 64'(bus.cdb_valid), 64'(0));
        tick();
        @(negedge clk);
        check("t1_valid",  64'(bus.cdb_valid),  64'(1));
        check("t1_result", 64'(bus.CDB_result), 64'(9'b000001000));
        check("t1_reg_we", 64'(bus.reg_we),     64'(1));
        tick();
        @(negedge clk);
        check("t1_one_cycle", 64'(bus.cdb_valid), 64'(0));
        settle("t1_sb_empty");

        // Back-to-back from FU1, no bubbles
        for (int k = 1; k <= 4; k++) begin
            drive(1, 5'd9, 32'(k));
            expect_bc(1, 5'd9, 32'(k));
            @(negedge clk);
            check("t3_ready", 64'(bus.req_ready[1]), 64'(1));
            if (k >= 3) check("t3_stream", 64'(bus.cdb_valid), 64'(1));
            tick();
        end
        bus.req_valid = '0;
        @(negedge clk);
        check("t3_stream3", 64'(bus.cdb_valid), 64'(1));
        tick();
        @(negedge clk);
        check("t3_stream4", 64'(bus.cdb_valid), 64'(1));
        tick();
        @(negedge clk);
        check("t3_done", 64'(bus.cdb_valid), 64'(0));
        settle("t3_sb_empty");

        // Tag 0 broadcasts but does not write the register file
        drive(4, 5'd0, 32'h55);
        expect_bc(4, 5'd0, 32'h55);
        tick();
        bus.req_valid = '0;
        tick();
        @(negedge clk);
        check("t4_valid",  64'(bus.cdb_valid),     64'(1));
        check("t4_bit5",   64'(bus.CDB_result[5]), 64'(1));
        check("t4_reg_we", 64'(bus.reg_we),        64'(0));
        settle("t4_sb_empty");

        // Flush of a loaded slot at its grant edge
        drive(5, 5'd7, 32'hA5A5);
        tick();
        bus.req_valid     = '0;
        bus.flush_mask[5] = 1'b1;
        check("t5_busy_before", 64'(bus.slots_busy), 64'(1));
        @(negedge clk);
        check("t5_ready_flushed", 64'(bus.req_ready[5]), 64'(0));
        tick();
        bus.flush_mask = '0;
        check("t5_busy_after", 64'(bus.slots_busy), 64'(0));
        @(negedge clk);
        check("t5_no_bc", 64'(bus.cdb_valid), 64'(0));
        settle("t5_sb_empty");
        check("t5_ready_empty", 64'(bus.req_ready[5]), 64'(1));

        // Flush while the output register holds FU5
        drive(5, 5'd7, 32'h1234);
        tick();
        bus.req_valid = '0;
        tick();
        check("t5b_valid_pre",  64'(bus.cdb_valid),  64'(1));
        check("t5b_result_pre", 64'(bus.CDB_result), 64'(9'b001000000));
        bus.flush_mask[5] = 1'b1;
        #1;
        check("t5b_valid_kill",  64'(bus.cdb_valid),  64'(0));
        check("t5b_result_kill", 64'(bus.CDB_result), 64'(1));
        check("t5b_reg_we_kill", 64'(bus.reg_we),     64'(0));
        tick();
        bus.flush_mask = '0;
        settle("t5b_sb_empty");

        // FU3 alone: moves the RR pointer to 4 before the contention case
        drive(3, 5'd3, 32'h33);
        expect_bc(3, 5'd3, 32'h33);
        tick();
        bus.req_valid = '0;
        settle("t2pre_sb_empty");

        // Contention among FU0, FU3, FU7
        drive(0, 5'd10, 32'hA0);
        drive(3, 5'd11, 32'hA3);
        drive(7, 5'd12, 32'hA7);
`ifdef CDB_RR_EN
        expect_bc(7, 5'd12, 32'hA7);
        expect_bc(0, 5'd10, 32'hA0);
        expect_bc(3, 5'd11, 32'hA3);
`else
        expect_bc(0, 5'd10, 32'hA0);
        expect_bc(3, 5'd11, 32'hA3);
        expect_bc(7, 5'd12, 32'hA7);
`endif
        tick();
        bus.req_valid = '0;
        check("t2_busy", 64'(bus.slots_busy), 64'(3));
        tick();
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("t2_consecutive", 64'(bus.cdb_valid), 64'(1));
            tick();
        end
        @(negedge clk);
        check("t2_done", 64'(bus.cdb_valid), 64'(0));
        settle("t2_sb_empty");

        // Async reset mid-broadcast with four slots full
        for (int i = 0; i < 4; i++) drive(i, 5'(i + 1), 32'h60 + 32'(i));
        tick();
        tick();
        check("t6_valid_pre", 64'(bus.cdb_valid),  64'(1));
        check("t6_busy_pre",  64'(bus.slots_busy), 64'(4));
        #1;
        rst = 1'b0;
        #1;
        check("t6_rst_valid",  64'(bus.cdb_valid),  64'(0));
        check("t6_rst_result", 64'(bus.CDB_result), 64'(1));
        check("t6_rst_tag",    64'(bus.cdb_tag),    64'(0));
        check("t6_rst_data",   64'(bus.cdb_data),   64'(0));
        check("t6_rst_reg_we", 64'(bus.reg_we),     64'(0));
        check("t6_rst_busy",   64'(bus.slots_busy), 64'(0));
        bus.req_valid = '0;
        tick();
        tick();
        @(negedge clk);
        rst = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            check("t6_quiet_valid", 64'(bus.cdb_valid),  64'(0));
            check("t6_quiet_busy",  64'(bus.slots_busy), 64'(0));
        end
        drive(6, 5'd6, 32'h66);
        expect_bc(6, 5'd6, 32'h66);
        tick();
        bus.req_valid = '0;
        settle("t6_sb_empty");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
